// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state type and frame constants for the UART receive path
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DATA_BITS     = 8;
  localparam int START_BIT_IDX = 0;
  localparam int PAR_BIT_IDX   = 9;

  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversampling edge counter and frame bit counter
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  bit_end
);

  assign bit_end = en && (edge_cnt == prescale - PRESCALE_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!en || clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_end) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receive sequencer driving sampler, deserializer and checker enables
module uart_rx_fsm
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  samp_en,
  output logic                  strt_chk_en,
  output logic                  deser_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  busy
);

  rx_state_t             state;
  logic [PRESCALE_W-1:0] p_lat;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  par_lat;
  logic                  par_flag;
  logic                  bit_end;
  logic                  cnt_en;
  logic                  cnt_clr;
  logic                  samp_pre;
  logic                  chk_pre;

  assign half     = p_lat >> 1;
  assign cnt_en   = (state != IDLE);
  assign cnt_clr  = bit_end && ((state == STOP) || ((state == START) && strt_glitch));
  // Outputs are registered, so decode one edge early; no state change happens mid-bit.
  assign samp_pre = (edge_cnt >= half - PRESCALE_W'(2)) && (edge_cnt <= half);
  assign chk_pre  = (edge_cnt == half + PRESCALE_W'(1));

  uart_rx_edge_bit_cnt #(
    .PRESCALE_W(PRESCALE_W),
    .BIT_CNT_W (BIT_CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .prescale(p_lat),
    .edge_cnt(edge_cnt),
    .bit_cnt (bit_cnt),
    .bit_end (bit_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      p_lat       <= '0;
      par_lat     <= 1'b0;
      par_flag    <= 1'b0;
      samp_en     <= 1'b0;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      samp_en     <= (state != IDLE) && samp_pre;
      strt_chk_en <= 1'b0;
      deser_en    <= 1'b0;
      par_chk_en  <= 1'b0;
      stp_chk_en  <= 1'b0;
      data_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_in) begin
            state   <= START;
            busy    <= 1'b1;
            p_lat   <= prescale;
            par_lat <= par_en;
          end
        end
        START: begin
          strt_chk_en <= chk_pre;
          if (bit_end) begin
            if (strt_glitch) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          deser_en <= chk_pre;
          if (bit_end && (bit_cnt == BIT_CNT_W'(DATA_BITS))) begin
            state <= par_lat ? PARITY : STOP;
          end
        end
        PARITY: begin
          par_chk_en <= chk_pre;
          if (bit_end) begin
            par_flag <= par_err;
            state    <= STOP;
          end
        end
        STOP: begin
          stp_chk_en <= chk_pre;
          if (bit_end) begin
            data_valid <= !stp_err && !par_flag;
            par_flag   <= 1'b0;
            state      <= IDLE;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - directed self-checking bench for uart_rx_fsm
module tb_uart_rx_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       par_en = 1'b0;
  logic       strt_glitch = 1'b0;
  logic       par_err = 1'b0;
  logic       stp_err = 1'b0;
  logic       samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy;

  int checks = 0;
  int errors = 0;

  logic deser_log [0:399];
  logic dv_log    [0:399];
  logic busy_log  [0:399];
  logic par_log   [0:399];
  logic strt_log  [0:399];
  logic stp_log   [0:399];
  int   deser_cnt, dv_cnt, par_cnt, samp_cnt;

  uart_rx_fsm #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .strt_glitch(strt_glitch),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .samp_en    (samp_en),
    .strt_chk_en(strt_chk_en),
    .deser_en   (deser_en),
    .par_chk_en (par_chk_en),
    .stp_chk_en (stp_chk_en),
    .data_valid (data_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Frame cycle n is the clock period after the n-th rising edge following the START entry edge.
  task automatic run_frame(input int p, input bit par, input logic [7:0] data,
                           input bit started, input bit b2b, input int ncycles);
    int   len;
    int   b;
    logic parity_bit;
    len = p * (par ? 11 : 10);
    parity_bit = ^data;
    for (int i = 0; i < 400; i++) begin
      deser_log[i] = 0; dv_log[i] = 0; busy_log[i] = 0;
      par_log[i] = 0; strt_log[i] = 0; stp_log[i] = 0;
    end
    deser_cnt = 0; dv_cnt = 0; par_cnt = 0; samp_cnt = 0;
    if (!started) begin
      @(negedge clk);
      prescale = p[5:0];
      par_en = par;
      rx_in = 1'b0;
      @(posedge clk);
    end
    for (int n = 0; n < ncycles; n++) begin
      @(negedge clk);
      deser_log[n] = deser_en; dv_log[n] = data_valid; busy_log[n] = busy;
      par_log[n] = par_chk_en; strt_log[n] = strt_chk_en; stp_log[n] = stp_chk_en;
      deser_cnt += int'(deser_en); dv_cnt += int'(data_valid);
      par_cnt += int'(par_chk_en); samp_cnt += int'(samp_en);
      if (n == 1) begin
        prescale = (p == 8) ? 6'd16 : 6'd8;
        par_en = !par;
      end
      if (n == len - 1) begin
        prescale = p[5:0];
        par_en = par;
      end
      b = n / p;
      if (n >= len) rx_in = !(b2b && n == len);
      else if (b == 0) rx_in = 1'b0;
      else if (b <= 8) rx_in = data[b-1];
      else if (par && b == 9) rx_in = parity_bit;
      else rx_in = 1'b1;
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy} !== 7'b0) begin
      errors++;
      $display("FAIL idle_outputs: got %b expected 0000000",
               {samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy});
    end
  endtask

  task automatic test_p8_nopar;
    run_frame(8, 1'b0, 8'hA5, 1'b0, 1'b0, 82);
    checks++;
    if (deser_cnt !== 8) begin errors++; $display("FAIL p8_deser_count: got %0d expected 8", deser_cnt); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (deser_log[14 + 8*k] !== 1'b1) begin
        errors++; $display("FAIL p8_deser_at_%0d: got %0d expected 1", 14 + 8*k, deser_log[14 + 8*k]);
      end
    end
    checks++;
    if (dv_cnt !== 1) begin errors++; $display("FAIL p8_dv_count: got %0d expected 1", dv_cnt); end
    checks++;
    if (dv_log[80] !== 1'b1) begin errors++; $display("FAIL p8_dv_at_80: got %0d expected 1", dv_log[80]); end
    checks++;
    if (samp_cnt !== 30) begin errors++; $display("FAIL p8_samp_count: got %0d expected 30", samp_cnt); end
    checks++;
    if (strt_log[6] !== 1'b1) begin errors++; $display("FAIL p8_strt_at_6: got %0d expected 1", strt_log[6]); end
    checks++;
    if (stp_log[78] !== 1'b1) begin errors++; $display("FAIL p8_stp_at_78: got %0d expected 1", stp_log[78]); end
    checks++;
    if ({busy_log[79], busy_log[80]} !== 2'b10) begin
      errors++; $display("FAIL p8_busy_79_80: got %b expected 10", {busy_log[79], busy_log[80]});
    end
  endtask

  task automatic test_p16_par;
    run_frame(16, 1'b1, 8'h3C, 1'b0, 1'b0, 178);
    checks++;
    if (par_log[154] !== 1'b1) begin errors++; $display("FAIL p16_par_at_154: got %0d expected 1", par_log[154]); end
    checks++;
    if (par_cnt !== 1) begin errors++; $display("FAIL p16_par_count: got %0d expected 1", par_cnt); end
    checks++;
    if (stp_log[170] !== 1'b1) begin errors++; $display("FAIL p16_stp_at_170: got %0d expected 1", stp_log[170]); end
    checks++;
    if (dv_log[176] !== 1'b1 || dv_cnt !== 1) begin
      errors++; $display("FAIL p16_dv_at_176: got %0d count %0d expected 1 count 1", dv_log[176], dv_cnt);
    end
    checks++;
    if (samp_cnt !== 33) begin errors++; $display("FAIL p16_samp_count: got %0d expected 33", samp_cnt); end
    checks++;
    if (deser_log[16 + 10] !== 1'b1) begin errors++; $display("FAIL p16_deser_at_26: got %0d expected 1", deser_log[26]); end
  endtask

  task automatic test_start_glitch;
    strt_glitch = 1'b1;
    run_frame(8, 1'b0, 8'hFF, 1'b0, 1'b0, 90);
    strt_glitch = 1'b0;
    checks++;
    if (strt_log[6] !== 1'b1) begin errors++; $display("FAIL glitch_strt_at_6: got %0d expected 1", strt_log[6]); end
    checks++;
    if ({busy_log[7], busy_log[8], busy_log[40]} !== 3'b100) begin
      errors++; $display("FAIL glitch_busy: got %b expected 100", {busy_log[7], busy_log[8], busy_log[40]});
    end
    checks++;
    if (deser_cnt !== 0 || dv_cnt !== 0) begin
      errors++; $display("FAIL glitch_no_pulses: got deser %0d dv %0d expected 0 0", deser_cnt, dv_cnt);
    end
    checks++;
    if (samp_cnt !== 3) begin errors++; $display("FAIL glitch_samp_count: got %0d expected 3", samp_cnt); end
  endtask

  task automatic test_parity_error;
    par_err = 1'b1;
    run_frame(8, 1'b1, 8'h81, 1'b0, 1'b0, 90);
    par_err = 1'b0;
    checks++;
    if (par_log[78] !== 1'b1) begin errors++; $display("FAIL perr_par_at_78: got %0d expected 1", par_log[78]); end
    checks++;
    if (dv_cnt !== 0) begin errors++; $display("FAIL perr_no_dv: got %0d expected 0", dv_cnt); end
    checks++;
    if ({busy_log[87], busy_log[88]} !== 2'b10) begin
      errors++; $display("FAIL perr_busy_87_88: got %b expected 10", {busy_log[87], busy_log[88]});
    end
    run_frame(8, 1'b1, 8'h0F, 1'b0, 1'b0, 90);
    checks++;
    if (dv_log[88] !== 1'b1 || dv_cnt !== 1) begin
      errors++; $display("FAIL perr_next_dv_at_88: got %0d count %0d expected 1 count 1", dv_log[88], dv_cnt);
    end
  endtask

  task automatic test_stop_error;
    stp_err = 1'b1;
    run_frame(8, 1'b0, 8'h33, 1'b0, 1'b0, 82);
    stp_err = 1'b0;
    checks++;
    if (stp_log[78] !== 1'b1) begin errors++; $display("FAIL serr_stp_at_78: got %0d expected 1", stp_log[78]); end
    checks++;
    if (dv_cnt !== 0) begin errors++; $display("FAIL serr_no_dv: got %0d expected 0", dv_cnt); end
    checks++;
    if ({busy_log[79], busy_log[80]} !== 2'b10) begin
      errors++; $display("FAIL serr_busy_79_80: got %b expected 10", {busy_log[79], busy_log[80]});
    end
  endtask

  task automatic test_reset_mid_frame;
    run_frame(32, 1'b0, 8'h96, 1'b0, 1'b0, 150);
    checks++;
    if (busy_log[149] !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %0d expected 1", busy_log[149]); end
    #2 rst = 1'b1;
    rx_in = 1'b1;
    prescale = 6'd32;
    par_en = 1'b0;
    #1;
    checks++;
    if ({samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got %b expected 0000000",
               {samp_en, strt_chk_en, deser_en, par_chk_en, stp_chk_en, data_valid, busy});
    end
    checks++;
    if (dut.state !== uart_rx_pkg::IDLE) begin
      errors++; $display("FAIL rst_mid_state: got %0d expected %0d", dut.state, uart_rx_pkg::IDLE);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_frame(32, 1'b0, 8'h6B, 1'b0, 1'b0, 322);
    checks++;
    if (dv_log[320] !== 1'b1 || dv_cnt !== 1) begin
      errors++; $display("FAIL rst_next_dv_at_320: got %0d count %0d expected 1 count 1", dv_log[320], dv_cnt);
    end
  endtask

  task automatic test_back_to_back;
    run_frame(32, 1'b0, 8'h5A, 1'b0, 1'b1, 321);
    checks++;
    if (dv_log[320] !== 1'b1 || dv_cnt !== 1) begin
      errors++; $display("FAIL b2b_first_dv: got %0d count %0d expected 1 count 1", dv_log[320], dv_cnt);
    end
    checks++;
    if (busy_log[320] !== 1'b0) begin errors++; $display("FAIL b2b_idle_in_dv: got %0d expected 0", busy_log[320]); end
    checks++;
    if (deser_cnt !== 8) begin errors++; $display("FAIL b2b_first_deser: got %0d expected 8", deser_cnt); end
    run_frame(32, 1'b0, 8'hC3, 1'b1, 1'b0, 322);
    checks++;
    if (busy_log[0] !== 1'b1) begin errors++; $display("FAIL b2b_second_busy_0: got %0d expected 1", busy_log[0]); end
    checks++;
    if (strt_log[18] !== 1'b1) begin errors++; $display("FAIL b2b_second_strt_18: got %0d expected 1", strt_log[18]); end
    checks++;
    if (dv_log[320] !== 1'b1 || dv_cnt !== 1) begin
      errors++; $display("FAIL b2b_second_dv: got %0d count %0d expected 1 count 1", dv_log[320], dv_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_p8_nopar;
    test_p16_par;
    test_start_glitch;
    test_parity_error;
    test_stop_error;
    test_reset_mid_frame;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-path sequencer for the UART RX. It detects the falling edge of the start bit and counts oversampling edges and bit positions. It drives one-cycle enable pulses to the data sampler, deserializer, start/parity/stop checkers, and raises `data_valid` for a frame that passes every check. It sits between the raw `rx_in` line and the RX datapath blocks, which hold no sequencing logic of their own.

## Interface
Parameters:
- `PRESCALE_W`, 6: width of the `prescale` input.
- `BIT_CNT_W`, 4: width of the internal bit counter; must hold values up to 10.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset; clears all state and outputs immediately.
- `rx_in`  in  1  synchronized serial line; idles high.
- `prescale`  in  `PRESCALE_W`  oversampling ratio P; legal values are 8, 16 and 32.
- `par_en`  in  1  1 means the frame carries a parity bit.
- `strt_glitch`  in  1  start-checker result; valid from the cycle after `strt_chk_en`.
- `par_err`  in  1  parity-checker result; valid from the cycle after `par_chk_en`.
- `stp_err`  in  1  stop-checker result; valid from the cycle after `stp_chk_en`.
- `samp_en`  out  1  high on the three majority-vote sample edges of every bit.
- `strt_chk_en`  out  1  one-cycle pulse enabling the start checker.
- `deser_en`  out  1  one-cycle pulse that shifts the sampled bit into the deserializer.
- `par_chk_en`  out  1  one-cycle pulse enabling the parity checker.
- `stp_chk_en`  out  1  one-cycle pulse enabling the stop checker.
- `data_valid`  out  1  one-cycle pulse: the frame is accepted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- All outputs reset to 0; the state resets to IDLE; both counters reset to 0.
- `prescale` and `par_en` are latched on the IDLE->START transition. Changing them mid-frame has no effect on that frame.
- Edge counter `edge_cnt` runs 0..P-1 within each bit. A "bit end" is the cycle with `edge_cnt`==P-1.
- Bit counter `bit_cnt` runs 0 (start), 1..8 (data), 9 (parity, if enabled), then the stop bit. It increments at each bit end.
- IDLE -> START when `rx_in`==0. The counters hold at 0 while in IDLE.
- `samp_en` is high when `edge_cnt` is P/2-1, P/2 or P/2+1, in every non-IDLE state.
- Check/shift pulses occur at `edge_cnt`==P/2+2:
  - START: `strt_chk_en`
  - DATA: `deser_en`
  - PARITY: `par_chk_en`
  - STOP: `stp_chk_en`
- START bit end:
  - `strt_glitch`=1 -> IDLE, with no further pulses for that frame.
  - Otherwise -> DATA.
- DATA bit end:
  - `bit_cnt`==8 and latched `par_en`=1 -> PARITY.
  - `bit_cnt`==8 and latched `par_en`=0 -> STOP.
  - Otherwise remain in DATA.
- PARITY bit end -> STOP. `par_err` is captured into a sticky frame-error flag.
- STOP bit end -> IDLE.
  - `data_valid` is registered high for the next cycle only if `stp_err`=0 and the sticky parity flag is 0.
  - The sticky flag clears on entry to IDLE.
- A frame with parity error or stop error produces no `data_valid` and still returns to IDLE normally.

## Timing
- First START cycle has `edge_cnt`=0 and counts as frame cycle 0.
- Frame length is 10·P cycles without parity and 11·P cycles with parity.
- `data_valid` is high in frame cycle 10·P (no parity) or 11·P (parity). The FSM is in IDLE in that cycle.
- Checker results are sampled at bit end, P/2-3 cycles after the enable pulse; this requires P≥8.
- `rx_in`==0 in the `data_valid` cycle is a legal back-to-back start: START is entered on the next cycle.
- `rst` asserted mid-frame clears everything asynchronously. No `data_valid` is issued for the aborted frame, and the first post-reset start is detected normally.
- Illegal `prescale` values give undefined results. Verification does not drive them.

## Structure
- Package `uart_rx_pkg` holds:
  - the state enum `rx_state_t`;
  - constants `DATA_BITS`=8, `START_BIT_IDX`=0 and `PAR_BIT_IDX`=9;
  - legal prescale constants 8, 16 and 32.
- Sub-module `uart_rx_edge_bit_cnt`: edge counter and bit counter with enable and wrap. The FSM instantiates it; it exposes `edge_cnt` and `bit_cnt`.

## Test plan
- P=8, `par_en`=0, frame 0xA5 with clean checkers:
  - `deser_en` fires 8 times, at frame cycles 14, 22, ..., 70.
  - `data_valid` is high at cycle 80 only.
- P=16, `par_en`=1, even parity, `par_err`=0:
  - `par_chk_en` is high at cycle 154.
  - `data_valid` is high at cycle 176.
- P=8, `strt_glitch`=1 after `strt_chk_en` -> IDLE at cycle 8, no `deser_en`, `busy` low from cycle 8.
- P=8, `par_en`=1, `par_err`=1 -> no `data_valid`, IDLE at cycle 88. The next clean frame is accepted.
- P=8, `stp_err`=1 -> no `data_valid`; `busy` drops at cycle 80.
- P=32:
  - `rst` pulsed at frame cycle 150 -> all outputs 0 asynchronously, state IDLE.
  - Back-to-back frames with `rx_in`=0 in the `data_valid` cycle -> both frames valid.
